// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: valid/ready data bus with variable response latency,
// load formatting (extension, LWL/LWR merge), alignment/timeout errors, optional posted-store buffer.
module mem_lsu #(
    parameter int ADDR_W    = 32,
    parameter int STORE_BUF = 1,
    parameter int TIMEOUT   = 0,
    parameter int TO_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [3:0]        mem_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       st_data,
    input  logic [31:0]       rt_old,
    input  logic              flush,
    output logic              stallreq,
    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic              exc_bus,
    output logic [ADDR_W-1:0] badvaddr,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wen,
    output logic [31:0]       bus_wdata,
    input  logic              bus_rsp_valid,
    input  logic [31:0]       bus_rsp_data
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    state_t            state;
    logic              drain, kill;
    logic [3:0]        op_r;
    logic [1:0]        k_r;
    logic [TO_W-1:0]   to_cnt;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [3:0]        buf_wen;
    logic [31:0]       buf_wdata;

    logic              is_load, is_store, misalign, want, post, accept, kill_now;
    logic [1:0]        k;
    logic [3:0]        wen_fmt;
    logic [31:0]       wdata_fmt;
    logic [ADDR_W-1:0] addr_fmt;

    function automatic logic [31:0] fmt_load(input logic [3:0] op, input logic [1:0] kk,
                                             input logic [31:0] m, input logic [31:0] rt);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(m >> {kk, 3'b000});
        h = kk[1] ? m[31:16] : m[15:0];
        case (op)
            4'd1: r = {{24{b[7]}}, b};
            4'd2: r = {24'd0, b};
            4'd3: r = {{16{h[15]}}, h};
            4'd4: r = {16'd0, h};
            4'd6: case (kk)
                      2'd0: r = {m[7:0],  rt[23:0]};
                      2'd1: r = {m[15:0], rt[15:0]};
                      2'd2: r = {m[23:0], rt[7:0]};
                      default: r = m;
                  endcase
            4'd7: case (kk)
                      2'd0: r = m;
                      2'd1: r = {rt[31:24], m[31:8]};
                      2'd2: r = {rt[31:16], m[31:16]};
                      default: r = {rt[31:8], m[31:24]};
                  endcase
            default: r = m;
        endcase
        return r;
    endfunction

    assign k = addr[1:0];

    always_comb begin
        is_load   = (mem_op >= 4'd1) && (mem_op <= 4'd7);
        is_store  = (mem_op >= 4'd8) && (mem_op <= 4'd12);
        misalign  = 1'b0;
        wen_fmt   = 4'h0;
        wdata_fmt = 32'h0;
        addr_fmt  = addr;
        case (mem_op)
            4'd3, 4'd4: misalign = addr[0];
            4'd5:       misalign = |addr[1:0];
            4'd6, 4'd7: addr_fmt = {addr[ADDR_W-1:2], 2'b00};
            4'd8:  begin wen_fmt = 4'b0001 << k; wdata_fmt = {4{st_data[7:0]}}; end
            4'd9:  begin
                misalign  = addr[0];
                wen_fmt   = k[1] ? 4'b1100 : 4'b0011;
                wdata_fmt = {2{st_data[15:0]}};
            end
            4'd10: begin misalign = |addr[1:0]; wen_fmt = 4'hF; wdata_fmt = st_data; end
            4'd11: begin
                addr_fmt = {addr[ADDR_W-1:2], 2'b00};
                case (k)
                    2'd0: wen_fmt = 4'b0001;
                    2'd1: wen_fmt = 4'b0011;
                    2'd2: wen_fmt = 4'b0111;
                    default: wen_fmt = 4'b1111;
                endcase
                wdata_fmt = st_data >> {~k, 3'b000};
            end
            4'd12: begin
                addr_fmt  = {addr[ADDR_W-1:2], 2'b00};
                wen_fmt   = 4'hF << k;
                wdata_fmt = st_data << {k, 3'b000};
            end
            default: ;
        endcase
    end

    assign exc_adel = op_valid && !flush && is_load && misalign;
    assign exc_ades = op_valid && !flush && is_store && misalign;
    assign badvaddr = (exc_adel || exc_ades) ? addr : '0;

    assign want     = op_valid && (is_load || is_store) && !flush && !misalign;
    assign post     = (STORE_BUF != 0) && is_store;
    assign accept   = (state == IDLE) && want && !buf_valid;
    assign kill_now = kill || (flush && !drain);

    // During a drain or a killed access the op in MEM is not ours yet: stall only if it needs the bus.
    always_comb begin
        case (state)
            IDLE:      stallreq = want && (buf_valid || !post);
            REQ, RESP: stallreq = (drain || kill) ? want : 1'b1;
            default:   stallreq = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE; drain <= 1'b0; kill <= 1'b0; op_r <= '0; k_r <= '0; to_cnt <= '0;
            buf_valid <= 1'b0; buf_addr <= '0; buf_wen <= '0; buf_wdata <= '0;
            ld_valid <= 1'b0; ld_data <= '0; exc_bus <= 1'b0;
            bus_req_valid <= 1'b0; bus_addr <= '0; bus_wen <= '0; bus_wdata <= '0;
        end else begin
            ld_valid <= 1'b0;
            exc_bus  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && post) begin
                        buf_valid <= 1'b1; buf_addr <= addr_fmt;
                        buf_wen <= wen_fmt; buf_wdata <= wdata_fmt;
                    end else if (accept) begin
                        state <= REQ; drain <= 1'b0; kill <= 1'b0; op_r <= mem_op; k_r <= k;
                        bus_req_valid <= 1'b1; bus_addr <= addr_fmt;
                        bus_wen <= wen_fmt; bus_wdata <= wdata_fmt;
                    end else if (buf_valid) begin
                        state <= REQ; drain <= 1'b1; kill <= 1'b0; op_r <= 4'd10;
                        bus_req_valid <= 1'b1; bus_addr <= buf_addr;
                        bus_wen <= buf_wen; bus_wdata <= buf_wdata;
                    end
                end
                REQ: begin
                    if (bus_req_ready) begin
                        // An accepted request is owed a response even if flushed.
                        state <= RESP; bus_req_valid <= 1'b0; to_cnt <= '0; kill <= kill_now;
                    end else if (flush && !drain) begin
                        state <= IDLE; bus_req_valid <= 1'b0;
                    end
                end
                RESP: begin
                    if (bus_rsp_valid) begin
                        if (drain) buf_valid <= 1'b0;
                        if (drain || kill_now) begin
                            state <= IDLE;
                        end else begin
                            state    <= DONE;
                            ld_valid <= (op_r <= 4'd7);
                            ld_data  <= fmt_load(op_r, k_r, bus_rsp_data, rt_old);
                        end
                    end else if ((TIMEOUT > 0) && (to_cnt == TO_LAST)) begin
                        exc_bus <= !kill_now;
                        if (drain) buf_valid <= 1'b0;
                        state <= (drain || kill_now) ? IDLE : DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        kill   <= kill_now;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: table of load/store/misaligned vectors plus
// hand-written sequences for store-buffer ordering, flush, timeout and reset.
module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [3:0]  mem_op;
    logic [31:0] addr, st_data, rt_old;
    logic        flush;
    logic        stallreq, ld_valid, exc_adel, exc_ades, exc_bus;
    logic [31:0] ld_data, badvaddr;
    logic        bus_req_valid, bus_req_ready, bus_rsp_valid;
    logic [31:0] bus_addr, bus_wdata, bus_rsp_data;
    logic [3:0]  bus_wen;

    mem_lsu #(.ADDR_W(32), .STORE_BUF(1), .TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .mem_op(mem_op), .addr(addr),
        .st_data(st_data), .rt_old(rt_old), .flush(flush), .stallreq(stallreq),
        .ld_valid(ld_valid), .ld_data(ld_data), .exc_adel(exc_adel), .exc_ades(exc_ades),
        .exc_bus(exc_bus), .badvaddr(badvaddr), .bus_req_valid(bus_req_valid),
        .bus_req_ready(bus_req_ready), .bus_addr(bus_addr), .bus_wen(bus_wen),
        .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr, wd, rt, mem, exp_data, exp_baddr;
        logic [3:0]  exp_wen;
        logic [1:0]  exp_exc;   // {adel, ades}
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        op_valid = 1'b0; mem_op = 4'd0; flush = 1'b0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    endtask

    task automatic do_load(input vec_t v, input string tag);
        op_valid = 1'b1; mem_op = v.op; addr = v.addr; rt_old = v.rt; st_data = 32'h0; #1;
        chk({tag, " stall@T"}, stallreq, 1);
        chk({tag, " req@T"}, bus_req_valid, 0);
        step(); bus_req_ready = 1'b1; #1;
        chk({tag, " req@T+1"}, bus_req_valid, 1);
        chk({tag, " bus_addr"}, bus_addr, v.exp_baddr);
        chk({tag, " bus_wen"}, bus_wen, 0);
        chk({tag, " stall@T+1"}, stallreq, 1);
        step(); bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rsp_data = v.mem; #1;
        chk({tag, " req@T+2"}, bus_req_valid, 0);
        chk({tag, " stall@T+2"}, stallreq, 1);
        step(); bus_rsp_valid = 1'b0; #1;
        chk({tag, " ld_valid@T+3"}, ld_valid, 1);
        chk({tag, " ld_data"}, ld_data, v.exp_data);
        chk({tag, " stall@T+3"}, stallreq, 0);
        step(); idle_in(); #1;
        chk({tag, " ld_valid pulse"}, ld_valid, 0);
    endtask

    task automatic do_store(input vec_t v, input string tag);
        op_valid = 1'b1; mem_op = v.op; addr = v.addr; st_data = v.wd; #1;
        chk({tag, " no stall"}, stallreq, 0);
        chk({tag, " req@accept"}, bus_req_valid, 0);
        step(); idle_in(); #1;
        chk({tag, " req before drain"}, bus_req_valid, 0);
        step();
        chk({tag, " drain req"}, bus_req_valid, 1);
        chk({tag, " bus_addr"}, bus_addr, v.exp_baddr);
        chk({tag, " bus_wen"}, bus_wen, v.exp_wen);
        chk({tag, " bus_wdata"}, bus_wdata, v.exp_data);
        bus_req_ready = 1'b1; step(); bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; #1;
        chk({tag, " req dropped"}, bus_req_valid, 0);
        step(); bus_rsp_valid = 1'b0; #1;
        chk({tag, " silent ack"}, ld_valid, 0);
    endtask

    task automatic do_mis(input vec_t v, input string tag);
        op_valid = 1'b1; mem_op = v.op; addr = v.addr; st_data = v.wd; #1;
        chk({tag, " adel"}, exc_adel, v.exp_exc[1]);
        chk({tag, " ades"}, exc_ades, v.exp_exc[0]);
        chk({tag, " badvaddr"}, badvaddr, v.exp_baddr);
        chk({tag, " stall"}, stallreq, 0);
        step();
        chk({tag, " no bus"}, bus_req_valid, 0);
        idle_in(); #1;
        chk({tag, " badvaddr cleared"}, badvaddr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          op     addr         wd            rt            mem           exp_data      exp_baddr     wen    exc
        vecs[0]  = '{4'd5, 32'h100, 32'h0,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h100, 4'h0, 2'b00};
        vecs[1]  = '{4'd1, 32'h103, 32'h0,        32'h0,        32'h80112233, 32'hFFFFFF80, 32'h103, 4'h0, 2'b00};
        vecs[2]  = '{4'd2, 32'h103, 32'h0,        32'h0,        32'h80112233, 32'h00000080, 32'h103, 4'h0, 2'b00};
        vecs[3]  = '{4'd3, 32'h102, 32'h0,        32'h0,        32'h80112233, 32'hFFFF8011, 32'h102, 4'h0, 2'b00};
        vecs[4]  = '{4'd4, 32'h100, 32'h0,        32'h0,        32'h80118233, 32'h00008233, 32'h100, 4'h0, 2'b00};
        vecs[5]  = '{4'd6, 32'h101, 32'h0,        32'hAABBCCDD, 32'h44332211, 32'h2211CCDD, 32'h100, 4'h0, 2'b00};
        vecs[6]  = '{4'd7, 32'h101, 32'h0,        32'hAABBCCDD, 32'h44332211, 32'hAA443322, 32'h100, 4'h0, 2'b00};
        vecs[7]  = '{4'd6, 32'h103, 32'h0,        32'hAABBCCDD, 32'h44332211, 32'h44332211, 32'h100, 4'h0, 2'b00};
        vecs[8]  = '{4'd7, 32'h102, 32'h0,        32'hAABBCCDD, 32'h44332211, 32'hAABB4433, 32'h100, 4'h0, 2'b00};
        vecs[9]  = '{4'd1, 32'h101, 32'h0,        32'h0,        32'h80112233, 32'h00000022, 32'h101, 4'h0, 2'b00};
        vecs[10] = '{4'd6, 32'h100, 32'h0,        32'hAABBCCDD, 32'h44332211, 32'h11BBCCDD, 32'h100, 4'h0, 2'b00};
        vecs[11] = '{4'd8, 32'h302, 32'h000000A5, 32'h0, 32'h0, 32'hA5A5A5A5, 32'h302, 4'h4, 2'b00};
        vecs[12] = '{4'd9, 32'h302, 32'h1234BEEF, 32'h0, 32'h0, 32'hBEEFBEEF, 32'h302, 4'hC, 2'b00};
        vecs[13] = '{4'd10, 32'h200, 32'hCAFEF00D, 32'h0, 32'h0, 32'hCAFEF00D, 32'h200, 4'hF, 2'b00};
        vecs[14] = '{4'd11, 32'h301, 32'h11223344, 32'h0, 32'h0, 32'h00001122, 32'h300, 4'h3, 2'b00};
        vecs[15] = '{4'd12, 32'h301, 32'h11223344, 32'h0, 32'h0, 32'h22334400, 32'h300, 4'hE, 2'b00};
        vecs[16] = '{4'd11, 32'h300, 32'h11223344, 32'h0, 32'h0, 32'h00000011, 32'h300, 4'h1, 2'b00};
        vecs[17] = '{4'd12, 32'h303, 32'h11223344, 32'h0, 32'h0, 32'h44000000, 32'h300, 4'h8, 2'b00};
        vecs[18] = '{4'd9, 32'h201, 32'h0, 32'h0, 32'h0, 32'h0, 32'h201, 4'h0, 2'b01};
        vecs[19] = '{4'd5, 32'h102, 32'h0, 32'h0, 32'h0, 32'h0, 32'h102, 4'h0, 2'b10};
        vecs[20] = '{4'd3, 32'h101, 32'h0, 32'h0, 32'h0, 32'h0, 32'h101, 4'h0, 2'b10};
        vecs[21] = '{4'd10, 32'h203, 32'h0, 32'h0, 32'h0, 32'h0, 32'h203, 4'h0, 2'b01};

        rst = 1'b1; idle_in(); addr = 32'h0; st_data = 32'h0; rt_old = 32'h0; bus_rsp_data = 32'h0;
        step(); step();
        chk("reset stallreq", stallreq, 0);
        chk("reset ld_valid", ld_valid, 0);
        chk("reset ld_data", ld_data, 0);
        chk("reset exc_bus", exc_bus, 0);
        chk("reset bus_req_valid", bus_req_valid, 0);
        chk("reset bus_addr", bus_addr, 0);
        chk("reset bus_wen", bus_wen, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].exp_exc != 2'b00)  do_mis(vecs[i], $sformatf("v%0d", i));
            else if (vecs[i].op <= 4'd7)   do_load(vecs[i], $sformatf("v%0d", i));
            else                           do_store(vecs[i], $sformatf("v%0d", i));
        end

        // SW then LW: store posts without stall, load waits for the drain ack
        op_valid = 1'b1; mem_op = 4'd10; addr = 32'h200; st_data = 32'h55AA55AA; #1;
        chk("sw-lw sw no stall", stallreq, 0);
        step(); mem_op = 4'd5; addr = 32'h204; #1;
        chk("sw-lw lw stall buf full", stallreq, 1);
        chk("sw-lw lw not issued", bus_req_valid, 0);
        step();
        chk("sw-lw drain req", bus_req_valid, 1);
        chk("sw-lw drain addr", bus_addr, 32'h200);
        chk("sw-lw drain wen", bus_wen, 4'hF);
        chk("sw-lw stall in drain", stallreq, 1);
        bus_req_ready = 1'b1; step(); bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; #1;
        chk("sw-lw stall await ack", stallreq, 1);
        step(); bus_rsp_valid = 1'b0; #1;
        chk("sw-lw ack silent", ld_valid, 0);
        chk("sw-lw lw accepted stall", stallreq, 1);
        step();
        chk("sw-lw lw req", bus_req_valid, 1);
        chk("sw-lw lw addr", bus_addr, 32'h204);
        chk("sw-lw lw wen", bus_wen, 4'h0);
        bus_req_ready = 1'b1; step(); bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b1; bus_rsp_data = 32'h12345678; #1;
        step(); bus_rsp_valid = 1'b0; #1;
        chk("sw-lw ld_valid", ld_valid, 1);
        chk("sw-lw ld_data", ld_data, 32'h12345678);
        step(); idle_in(); #1;

        // flush while awaiting the response
        op_valid = 1'b1; mem_op = 4'd5; addr = 32'h100; #1;
        step(); bus_req_ready = 1'b1;
        step(); bus_req_ready = 1'b0; flush = 1'b1; #1;
        step(); flush = 1'b0; op_valid = 1'b0; mem_op = 4'd0;
        bus_rsp_valid = 1'b1; bus_rsp_data = 32'h0BADF00D; #1;
        chk("flush-resp no stall", stallreq, 0);
        step(); bus_rsp_valid = 1'b0; #1;
        chk("flush-resp no ld_valid", ld_valid, 0);
        step();
        chk("flush-resp no ld_valid+1", ld_valid, 0);
        chk("flush-resp bus idle", bus_req_valid, 0);
        do_load(vecs[0], "post-flush");

        // flush while the request is still pending
        op_valid = 1'b1; mem_op = 4'd5; addr = 32'h100; #1;
        step();
        chk("flush-req req up", bus_req_valid, 1);
        flush = 1'b1; step(); flush = 1'b0; op_valid = 1'b0; mem_op = 4'd0; #1;
        chk("flush-req req dropped", bus_req_valid, 0);
        chk("flush-req no stall", stallreq, 0);
        step();
        chk("flush-req no ld_valid", ld_valid, 0);
        chk("flush-req still idle", bus_req_valid, 0);

        // response timeout after 4 RESP cycles
        op_valid = 1'b1; mem_op = 4'd5; addr = 32'h100; #1;
        step(); bus_req_ready = 1'b1; step(); bus_req_ready = 1'b0; #1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("timeout exc_bus low c%0d", c), exc_bus, 0);
            chk($sformatf("timeout stall c%0d", c), stallreq, 1);
            step();
        end
        chk("timeout exc_bus pulse", exc_bus, 1);
        chk("timeout no ld_valid", ld_valid, 0);
        chk("timeout no stall", stallreq, 0);
        step(); idle_in(); #1;
        chk("timeout exc_bus one cycle", exc_bus, 0);

        // reset with a store sitting in the buffer discards it
        op_valid = 1'b1; mem_op = 4'd10; addr = 32'h400; st_data = 32'h1; #1;
        step(); idle_in(); rst = 1'b1; #1;
        step(); rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("rst-mid no drain c%0d", c), bus_req_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
